product_accumulator: RTL

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/product_accumulator.sv | 111 +++++++++++
 1 files changed

// File: rtl/product_accumulator.sv
// Frame accumulator for unsigned 4x4 products: sums terms until in_last or MAX_TERMS, then holds the result.
// Define PRODUCT_ACCUMULATOR_SAT_EN to clamp on overflow instead of wrapping.
module product_accumulator #(
    parameter int ACC_W     = 12,
    parameter int MAX_TERMS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [4:0]       term_cnt,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [4:0]       MAX_CNT = 5'(MAX_TERMS);
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    state_t           state, state_nxt;
    logic             live;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [4:0]       cnt, cnt_nxt;
    logic             ovf_run, ovf_nxt;
    logic             close;
    logic             accept;
    logic [ACC_W:0]   sum;

    assign accept = in_valid & in_ready;
    assign sum    = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, prod};

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf_run;
        close     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    acc_nxt   = {{(ACC_W - 8){1'b0}}, prod};
                    cnt_nxt   = 5'd1;
                    ovf_nxt   = 1'b0;
                    close     = in_last;
                    state_nxt = in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
                    acc_nxt = sum[ACC_W] ? ACC_MAX : sum[ACC_W-1:0];
`else
                    acc_nxt = sum[ACC_W-1:0];
`endif
                    cnt_nxt   = cnt + 5'd1;
                    ovf_nxt   = ovf_run | sum[ACC_W];
                    close     = in_last | (cnt_nxt == MAX_CNT);
                    state_nxt = close ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // live keeps in_ready low while reset is held and until the first edge after release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            live    <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            ovf_run <= 1'b0;
        end else begin
            state   <= state_nxt;
            live    <= 1'b1;
            acc     <= acc_nxt;
            cnt     <= cnt_nxt;
            ovf_run <= ovf_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_out  <= '0;
            term_cnt <= '0;
            ovf      <= 1'b0;
        end else if (close) begin
            acc_out  <= acc_nxt;
            term_cnt <= cnt_nxt;
            ovf      <= ovf_nxt;
        end
    end

    assign in_ready  = live & (state != HOLD);
    assign out_valid = (state == HOLD);

endmodule
